// File: rtl/demux3_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshake and a one-word holding register per port.
// Optional per-port 8-bit saturating handshake counters are enabled by defining DEMUX3_CNT_EN.
module demux3_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] Din,
  input  logic         S0,
  input  logic         S1,
  input  logic         In_valid,
  output logic         In_ready,
  output logic [W-1:0] Out0,
  output logic [W-1:0] Out1,
  output logic [W-1:0] Out2,
  output logic         V0,
  output logic         V1,
  output logic         V2,
  input  logic         R0,
  input  logic         R1,
  input  logic         R2
`ifdef DEMUX3_CNT_EN
  ,
  output logic [7:0]   Cnt0,
  output logic [7:0]   Cnt1,
  output logic [7:0]   Cnt2
`endif
);

  localparam int unsigned NP = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } port_state_e;

  port_state_e  state_q [NP];
  port_state_e  state_d [NP];
  logic [W-1:0] data_q  [NP];
  logic [W-1:0] data_d  [NP];

  logic [NP-1:0] sel_c;
  logic [NP-1:0] rdy_c;
  logic [NP-1:0] load_c;
  logic [NP-1:0] drain_c;
  logic          accept_c;

  // One-hot target decode, same S1/S0 mapping as mux3 (S1 dominates).
  always_comb begin
    sel_c = 3'b001;
    if (S1) begin
      sel_c = 3'b100;
    end else if (S0) begin
      sel_c = 3'b010;
    end
  end

  assign rdy_c = {R2, R1, R0};

  // Only the addressed port gates acceptance; In_valid never feeds In_ready.
  always_comb begin
    In_ready = 1'b0;
    for (int n = 0; n < NP; n++) begin
      if (sel_c[n]) begin
        In_ready = (state_q[n] == EMPTY) | rdy_c[n];
      end
    end
  end

  assign accept_c = In_valid & In_ready;

  always_comb begin
    load_c  = '0;
    drain_c = '0;
    for (int n = 0; n < NP; n++) begin
      load_c[n]  = sel_c[n] & accept_c;
      drain_c[n] = (state_q[n] == FULL) & rdy_c[n];
    end
  end

  // Per-port EMPTY/FULL next state; a load wins over a same-cycle drain.
  always_comb begin
    for (int n = 0; n < NP; n++) begin
      state_d[n] = state_q[n];
      data_d[n]  = data_q[n];
    end
    for (int n = 0; n < NP; n++) begin
      case (state_q[n])
        EMPTY: begin
          if (load_c[n]) begin
            state_d[n] = FULL;
            data_d[n]  = Din;
          end
        end
        FULL: begin
          if (load_c[n]) begin
            data_d[n] = Din;
          end else if (drain_c[n]) begin
            state_d[n] = EMPTY;
          end
        end
        default: state_d[n] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NP; n++) begin
        state_q[n] <= EMPTY;
        data_q[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NP; n++) begin
        state_q[n] <= state_d[n];
        data_q[n]  <= data_d[n];
      end
    end
  end

  assign Out0 = data_q[0];
  assign Out1 = data_q[1];
  assign Out2 = data_q[2];
  assign V0   = (state_q[0] == FULL);
  assign V1   = (state_q[1] == FULL);
  assign V2   = (state_q[2] == FULL);

`ifdef DEMUX3_CNT_EN
  localparam int unsigned CW = 8;

  logic [CW-1:0] cnt_q [NP];
  logic [CW-1:0] cnt_d [NP];

  // Output-handshake counters, saturating at all-ones.
  always_comb begin
    for (int n = 0; n < NP; n++) begin
      cnt_d[n] = cnt_q[n];
      if (drain_c[n] && (cnt_q[n] != {CW{1'b1}})) begin
        cnt_d[n] = cnt_q[n] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NP; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NP; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign Cnt0 = cnt_q[0];
  assign Cnt1 = cnt_q[1];
  assign Cnt2 = cnt_q[2];
`endif

endmodule
